// File: rtl/rv_chk_pkg.sv
// Shared definitions for the RV32 trace checker: entry layout, FSM states, ABI/magic constants.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package rv_chk_pkg;

  // Checker run states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // ABI register a0 carries the pass/fail magic value
  localparam logic [4:0]  A0             = 5'd10;
  localparam logic [31:0] PASS_MAGIC_DEF = 32'h00c0ffee;
  localparam logic [31:0] FAIL_MAGIC_DEF = 32'hdeaddead;

  // Entry layout, MSB first: {chk_pc, chk_reg, rd[4:0], pc, value}
  localparam int RD_W      = 5;
  localparam int FLAG_W    = 2;
  localparam int VALUE_LSB = 0;

  function automatic int entry_w(input int xlen);
    return FLAG_W + RD_W + 2 * xlen;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int rd_lsb(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int chk_reg_bit(input int xlen);
    return 2 * xlen + RD_W;
  endfunction

  function automatic int chk_pc_bit(input int xlen);
    return 2 * xlen + RD_W + 1;
  endfunction

endpackage

// File: rtl/rv_trace_ram.sv
// Expected-trace table: DEPTH entries, synchronous write, asynchronous read.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none, one write per cycle.
module rv_trace_ram
  import rv_chk_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = entry_w(32),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Table write port; contents survive reset on purpose so a trace can be rerun
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_trace_checker.sv
// Commit-trace checker: compares retired instructions to a loaded table, watches a0 magic and timeout.
// Latency: offending/magic commit sampled at edge N, done and flags visible right after N (1 cycle).
// Backpressure: none, one commit accepted every cycle. Option CHK_STOP_ON_ERR_EN: stop on first mismatch.
module rv_trace_checker
  import rv_chk_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 256,
  parameter int              MAXCYCLES  = 10000,
  parameter logic [XLEN-1:0] PASS_MAGIC = XLEN'(PASS_MAGIC_DEF),
  parameter logic [XLEN-1:0] FAIL_MAGIC = XLEN'(FAIL_MAGIC_DEF),
  localparam int             AW         = $clog2(DEPTH),
  localparam int             EW         = entry_w(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [EW-1:0]   ld_data,
  input  logic [AW:0]     ld_len,
  input  logic            start,
  input  logic            cm_valid,
  input  logic [XLEN-1:0] cm_pc,
  input  logic            cm_we,
  input  logic [4:0]      cm_rd,
  input  logic [XLEN-1:0] cm_wdata,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [15:0]     err_cnt,
  output logic [AW:0]     first_err,
  output logic [31:0]     cyc_cnt,
  output logic [AW:0]     idx
);

  localparam int PC_LSB  = pc_lsb(XLEN);
  localparam int RD_LSB  = rd_lsb(XLEN);
  localparam int CREG_B  = chk_reg_bit(XLEN);
  localparam int CPC_B   = chk_pc_bit(XLEN);

  chk_state_e state, state_n;

  logic [AW:0]     len_q;
  logic [EW-1:0]   rdata;
  logic [XLEN-1:0] e_value;
  logic [XLEN-1:0] e_pc;
  logic [4:0]      e_rd;
  logic            e_chk_reg;
  logic            e_chk_pc;

  logic            cmp_en;
  logic            pc_bad;
  logic            reg_bad;
  logic            mismatch;
  logic            is_a0;
  logic            magic_pass;
  logic            magic_fail;
  logic            stop_err;
  logic            hit_max;
  logic [31:0]     cyc_n;
  logic [15:0]     err_n;

  // Table loads are only honoured outside RUN so a live run sees a stable trace
  rv_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clock (clock),
    .we    (ld_we && (state != RUN)),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (idx[AW-1:0]),
    .rdata (rdata)
  );

  assign e_value   = rdata[VALUE_LSB +: XLEN];
  assign e_pc      = rdata[PC_LSB +: XLEN];
  assign e_rd      = rdata[RD_LSB +: RD_W];
  assign e_chk_reg = rdata[CREG_B];
  assign e_chk_pc  = rdata[CPC_B];

  // Only commits inside the loaded trace are compared; the rest only feed magic detection
  assign cmp_en   = (state == RUN) && cm_valid && (idx < len_q);
  assign pc_bad   = e_chk_pc && (cm_pc != e_pc);
  // rd compare also makes an x0 write fail against any entry expecting rd != 0
  assign reg_bad  = e_chk_reg && (!cm_we || (cm_rd != e_rd) || (cm_wdata != e_value));
  assign mismatch = cmp_en && (pc_bad || reg_bad);

  assign is_a0      = (state == RUN) && cm_valid && cm_we && (cm_rd == A0);
  assign magic_pass = is_a0 && (cm_wdata == PASS_MAGIC);
  assign magic_fail = is_a0 && (cm_wdata == FAIL_MAGIC);

  assign cyc_n   = cyc_cnt + 32'd1;
  assign hit_max = (state == RUN) && (cyc_n == 32'(MAXCYCLES));
  assign err_n   = (mismatch && (err_cnt != 16'hffff)) ? err_cnt + 16'd1 : err_cnt;

`ifdef CHK_STOP_ON_ERR_EN
  assign stop_err = mismatch;
`else
  assign stop_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: start leaves IDLE/DONE, any terminating event ends RUN
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (magic_pass || magic_fail || stop_err || hit_max) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Run counters and result flags; magic outranks timeout on the same commit
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q     <= '0;
      idx       <= '0;
      err_cnt   <= '0;
      first_err <= '1;
      cyc_cnt   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else if ((state != RUN) && start) begin
      len_q     <= ld_len;
      idx       <= '0;
      err_cnt   <= '0;
      first_err <= '1;
      cyc_cnt   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else if (state == RUN) begin
      cyc_cnt <= cyc_n;
      err_cnt <= err_n;
      if (cmp_en) begin
        idx <= idx + (AW+1)'(1);
      end
      if (mismatch && (first_err == '1)) begin
        first_err <= idx;
      end
      if (magic_pass) begin
        pass <= (err_n == 16'd0);
        fail <= (err_n != 16'd0);
      end else if (magic_fail) begin
        fail <= 1'b1;
      end else begin
        if (stop_err) begin
          fail <= 1'b1;
        end
        if (hit_max) begin
          timeout <= 1'b1;
          fail    <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rv_trace_checker.sv
// Bench for rv_trace_checker: directed and random traces, scoreboard of end-of-run results.
// Latency: results compared on the negedge after done rises.
// Backpressure: none; commits driven every cycle.
module tb_rv_trace_checker;

  localparam int MAXC = 50;
  localparam int DEP  = 16;
  localparam logic [31:0] PASSM = 32'h00c0ffee;
  localparam logic [31:0] FAILM = 32'hdeaddead;
`ifdef CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    bit        chk_pc;
    bit        chk_reg;
    bit [4:0]  rd;
    bit [31:0] pc;
    bit [31:0] value;
  } ent_t;

  typedef struct {
    bit        valid;
    bit        we;
    bit [4:0]  rd;
    bit [31:0] pc;
    bit [31:0] wdata;
  } cm_t;

  typedef struct {
    bit pass;
    bit fail;
    bit tmo;
    int err;
    int fe;
    int idx;
    int cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [70:0] ld_data = '0;
  logic [4:0]  ld_len = '0;
  logic        start = 1'b0;
  logic        cm_valid = 1'b0;
  logic [31:0] cm_pc = '0;
  logic        cm_we = 1'b0;
  logic [4:0]  cm_rd = '0;
  logic [31:0] cm_wdata = '0;
  logic        busy, done, pass, fail, timeout;
  logic [15:0] err_cnt;
  logic [4:0]  first_err;
  logic [31:0] cyc_cnt;
  logic [4:0]  idx;

  int   checks = 0;
  int   errors = 0;
  ent_t tr [DEP];
  cm_t  cur_cm [$];
  exp_t expq [$];
  bit   done_seen = 1'b0;

  rv_trace_checker #(
    .XLEN       (32),
    .DEPTH      (DEP),
    .MAXCYCLES  (MAXC),
    .PASS_MAGIC (PASSM),
    .FAIL_MAGIC (FAILM)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_len    (ld_len),
    .start     (start),
    .cm_valid  (cm_valid),
    .cm_pc     (cm_pc),
    .cm_we     (cm_we),
    .cm_rd     (cm_rd),
    .cm_wdata  (cm_wdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .err_cnt   (err_cnt),
    .first_err (first_err),
    .cyc_cnt   (cyc_cnt),
    .idx       (idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk the commit list cycle by cycle applying the checker rules
  function automatic exp_t model(input int len);
    exp_t e;
    cm_t  m;
    int   k, errs, fe;
    bit   mis, mp, mf;
    e = '{default: 0};
    k = 0; errs = 0; fe = -1;
    for (int c = 1; c <= MAXC; c++) begin
      if (c - 1 < cur_cm.size()) m = cur_cm[c-1];
      else m = '{default: 0};
      mis = 1'b0;
      if (m.valid && k < len) begin
        if (tr[k].chk_pc && m.pc != tr[k].pc) mis = 1'b1;
        if (tr[k].chk_reg && !(m.we && m.rd == tr[k].rd && m.wdata == tr[k].value)) mis = 1'b1;
        if (mis) begin
          errs++;
          if (fe < 0) fe = k;
        end
        k++;
      end
      mp = m.valid && m.we && m.rd == 5'd10 && m.wdata == PASSM;
      mf = m.valid && m.we && m.rd == 5'd10 && m.wdata == FAILM;
      e.err = errs; e.fe = fe; e.idx = k; e.cyc = c;
      if (mp) begin
        e.pass = (errs == 0); e.fail = (errs != 0);
        return e;
      end
      if (mf) begin
        e.fail = 1'b1;
        return e;
      end
      if (STOP && mis) begin
        e.fail = 1'b1; e.tmo = (c == MAXC);
        return e;
      end
      if (c == MAXC) begin
        e.fail = 1'b1; e.tmo = 1'b1;
        return e;
      end
    end
    return e;
  endfunction

  // Monitor: each rising done pops one expected result
  always @(negedge clock) begin
    exp_t e;
    if (done && !done_seen) begin
      if (expq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("busy_at_done", int'(busy), 0);
        chk("pass", int'(pass), int'(e.pass));
        chk("fail", int'(fail), int'(e.fail));
        chk("timeout", int'(timeout), int'(e.tmo));
        chk("err_cnt", int'(err_cnt), e.err);
        chk("first_err", int'(first_err), (e.fe < 0) ? 31 : e.fe);
        chk("idx", int'(idx), e.idx);
        chk("cyc_cnt", int'(cyc_cnt), e.cyc);
      end
    end
    done_seen = done;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_first_err"}, int'(first_err), 31);
    chk({tag, "_cyc_cnt"}, int'(cyc_cnt), 0);
    chk({tag, "_idx"}, int'(idx), 0);
  endtask

  task automatic push_cm(input bit v, input bit [31:0] pc, input bit we,
                         input bit [4:0] rd, input bit [31:0] wd);
    cm_t c;
    c.valid = v; c.pc = pc; c.we = we; c.rd = rd; c.wdata = wd;
    cur_cm.push_back(c);
  endtask

  task automatic set_ent(input int i, input bit cpc, input bit creg, input bit [4:0] rd,
                         input bit [31:0] pc, input bit [31:0] val);
    tr[i].chk_pc = cpc; tr[i].chk_reg = creg; tr[i].rd = rd; tr[i].pc = pc; tr[i].value = val;
  endtask

  task automatic present(input int j);
    if (j < cur_cm.size()) begin
      cm_valid = cur_cm[j].valid; cm_pc = cur_cm[j].pc; cm_we = cur_cm[j].we;
      cm_rd = cur_cm[j].rd; cm_wdata = cur_cm[j].wdata;
    end else begin
      cm_valid = 1'b0; cm_pc = '0; cm_we = 1'b0; cm_rd = '0; cm_wdata = '0;
    end
  endtask

  task automatic load_trace(input int len);
    for (int i = 0; i < len; i++) begin
      @(posedge clock); #1;
      ld_we = 1'b1; ld_addr = 4'(i);
      ld_data = {tr[i].chk_pc, tr[i].chk_reg, tr[i].rd, tr[i].pc, tr[i].value};
    end
  endtask

  // Start issued the cycle right after the last table write
  task automatic start_run(input int len);
    @(posedge clock); #1;
    ld_we = 1'b0; ld_len = 5'(len); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // poke: pulse start and a junk table write during RUN; both must be ignored
  task automatic run(input int len, input bit load, input bit poke);
    bit got;
    int j;
    if (load) load_trace(len);
    expq.push_back(model(len));
    start_run(len);
    j = 0; got = 1'b0;
    present(0);
    for (int t = 0; t < 3 * MAXC; t++) begin
      if (poke && t == 0) begin
        start = 1'b1;
        if (len >= 2) begin
          ld_we = 1'b1; ld_addr = 4'(len - 1); ld_data = '1;
        end
      end
      @(posedge clock); #1;
      start = 1'b0; ld_we = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      j++;
      present(j);
    end
    present(-1);
    if (!got) chk("run_done_within_bound", 0, 1);
    @(negedge clock); #1;
  endtask

  task automatic add_trace();
    set_ent(0, 1, 1, 5'd6, 32'h0, 32'd100);
    set_ent(1, 1, 1, 5'd7, 32'h4, 32'd20);
    set_ent(2, 1, 1, 5'd28, 32'h8, 32'd120);
  endtask

  task automatic gen_random(output int len);
    cm_t c;
    len = $urandom_range(0, 8);
    cur_cm.delete();
    for (int i = 0; i < len; i++) begin
      set_ent(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              32'(i * 4), 32'($urandom_range(0, 65535)));
    end
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) push_cm(0, 0, 0, 0, 0);
      c.valid = 1'b1; c.pc = tr[i].pc; c.rd = tr[i].rd; c.wdata = tr[i].value;
      c.we = tr[i].chk_reg ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: c.pc = c.pc + 32'd4;
          1: c.wdata = c.wdata ^ 32'd1;
          2: c.we = 1'b0;
          default: c.rd = (c.rd == 5'd0) ? 5'd5 : 5'd0;
        endcase
      end
      cur_cm.push_back(c);
    end
    repeat ($urandom_range(0, 2))
      push_cm(1, 32'($urandom_range(0, 255)), 1, 5'($urandom_range(0, 31)), 32'($urandom_range(0, 999)));
    case ($urandom_range(0, 5))
      0: push_cm(1, 32'(len * 4), 1, 5'd10, FAILM);
      1: ;
      default: push_cm(1, 32'(len * 4), 1, 5'd10, PASSM);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_idle("reset");

    // add trace then pass magic
    add_trace();
    cur_cm.delete();
    push_cm(1, 32'h0, 1, 5'd6, 32'd100);
    push_cm(1, 32'h4, 1, 5'd7, 32'd20);
    push_cm(1, 32'h8, 1, 5'd28, 32'd120);
    push_cm(1, 32'hc, 1, 5'd10, PASSM);
    run(3, 1, 0);

    // third result wrong
    cur_cm[2].wdata = 32'd121;
    run(3, 1, 1);

    // no magic: timeout
    cur_cm.delete();
    push_cm(1, 32'h0, 1, 5'd6, 32'd100);
    push_cm(1, 32'h4, 1, 5'd7, 32'd20);
    push_cm(1, 32'h8, 1, 5'd28, 32'd120);
    run(3, 1, 0);

    // fail magic with empty trace
    cur_cm.delete();
    push_cm(1, 32'h0, 1, 5'd10, FAILM);
    run(0, 0, 0);

    // pass magic on exactly the timeout cycle
    cur_cm.delete();
    repeat (MAXC - 1) push_cm(0, 0, 0, 0, 0);
    push_cm(1, 32'h40, 1, 5'd10, PASSM);
    run(0, 0, 0);

    // x0 write against an entry expecting x5
    set_ent(0, 0, 1, 5'd5, 32'h0, 32'd7);
    cur_cm.delete();
    push_cm(1, 32'h0, 1, 5'd0, 32'd7);
    push_cm(1, 32'h4, 1, 5'd10, PASSM);
    run(1, 1, 0);

    // reset mid-run, then rerun the untouched table
    add_trace();
    cur_cm.delete();
    push_cm(1, 32'h0, 1, 5'd6, 32'd100);
    push_cm(1, 32'h4, 1, 5'd7, 32'd20);
    push_cm(1, 32'h8, 1, 5'd28, 32'd120);
    repeat (4) push_cm(0, 0, 0, 0, 0);
    push_cm(1, 32'hc, 1, 5'd10, PASSM);
    load_trace(3);
    start_run(3);
    for (int j = 0; j < 5; j++) begin
      present(j);
      @(posedge clock); #1;
    end
    present(-1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_idle("midrun_reset");
    run(3, 0, 0);

    // interleaved bubbles with a branch gap
    add_trace();
    set_ent(3, 1, 0, 5'd0, 32'hc, 32'd0);
    set_ent(4, 1, 1, 5'd10, 32'h14, PASSM);
    cur_cm.delete();
    push_cm(1, 32'h0, 1, 5'd6, 32'd100);
    push_cm(0, 0, 0, 0, 0);
    push_cm(1, 32'h4, 1, 5'd7, 32'd20);
    push_cm(0, 0, 0, 0, 0);
    push_cm(0, 0, 0, 0, 0);
    push_cm(1, 32'h8, 1, 5'd28, 32'd120);
    push_cm(1, 32'hc, 0, 5'd0, 32'd0);
    push_cm(0, 0, 0, 0, 0);
    push_cm(1, 32'h14, 1, 5'd10, PASSM);
    run(5, 1, 0);

    // random traces
    for (int r = 0; r < 30; r++) begin
      gen_random(len);
      run(len, 1, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
